// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// reset PC, bus size encoding, IF->ID bus width and PC-source selection.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
  localparam int          PC_W_DEFAULT     = 32;

  // Size field of the SRAM-like bus: 2'd2 selects a 4-byte word access.
  localparam logic [1:0]  INST_SIZE_WORD   = 2'd2;

  // {fs_pc, fs_inst} as carried from IF to ID.
  localparam int          FS_TO_DS_BUS_WR  = 64;

  // Fetch FSM: request, wait for data, hold until ID takes the instruction.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fs_state_t;

  // Where the next fetch address comes from at hand-off.
  typedef enum logic {
    PC_SRC_SEQ = 1'b0,  // fall through to pc + 4
    PC_SRC_ID  = 1'b1   // target supplied by ID (jump, branch, register)
  } pc_src_t;

  // Sequential successor of a fetch PC; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction bus between the fetch stage (master) and memory (slave).
interface if_fetch_ctrl_if #(
  parameter int PC_W = 32
);
  logic            req;
  logic            wr;
  logic [1:0]      size;
  logic [PC_W-1:0] addr;
  logic            addr_ok;
  logic            data_ok;
  logic [PC_W-1:0] rdata;

  modport master (
    output req, wr, size, addr,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage controller: owns the fetch PC, issues one word read
// at a time on the instruction bus and buffers the returned word until ID
// accepts it. Optional redirect port enabled by the macro IF_FLUSH_EN.
//
// Handshakes:
//   bus request : a request is accepted in a cycle where req & addr_ok; req and
//                 addr stay constant until then. The response is the first
//                 data_ok after acceptance, never in the acceptance cycle.
//   IF -> ID    : an instruction moves in a cycle where fs_to_ds_valid &
//                 ds_allowin; until then {fs_pc, fs_inst} are held stable.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = PC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_nextpc_valid,
  input  logic [PC_W-1:0]   id_nextpc,
  output logic [PC_W-1:0]   fs_pc,
  if_fetch_ctrl_if.master   inst_sram,
  input  logic              ds_allowin,
  output logic              fs_to_ds_valid,
  output logic [PC_W-1:0]   fs_inst,
`ifdef IF_FLUSH_EN
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
`endif
  output fs_state_t         dbg_state
);

  fs_state_t       state;
  fs_state_t       state_nxt;
  logic            discard;
  logic            req_fire;
  logic            handoff;
  logic            redirect;
  pc_src_t         pc_src;
  logic [PC_W-1:0] next_pc;

`ifdef IF_FLUSH_EN
  assign redirect = flush;
`else
  assign redirect = 1'b0;
`endif

  // Requests are held off while a stale response is still owed by the bus.
  assign inst_sram.req  = (state == S_REQ) && !discard && !reset;
  assign inst_sram.wr   = 1'b0;
  assign inst_sram.size = INST_SIZE_WORD;
  assign inst_sram.addr = fs_pc;

  assign req_fire       = inst_sram.req && inst_sram.addr_ok;
  assign fs_to_ds_valid = (state == S_HOLD);
  assign handoff        = fs_to_ds_valid && ds_allowin;
  assign dbg_state      = state;

  // ID's target applies to the instruction after the one now in IF.
  assign pc_src  = id_nextpc_valid ? PC_SRC_ID : PC_SRC_SEQ;
  assign next_pc = (pc_src == PC_SRC_ID) ? id_nextpc : seq_pc(fs_pc);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  // Next-state logic; a redirect always restarts at the request state.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ:   if (req_fire)           state_nxt = S_WAIT;
        S_WAIT:  if (inst_sram.data_ok)  state_nxt = S_HOLD;
        S_HOLD:  if (ds_allowin)         state_nxt = S_REQ;
        default:                         state_nxt = S_REQ;
      endcase
    end
  end

  // Fetch PC: reset, redirect, then sequential/ID-selected advance at hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_pc <= RESET_PC;
`ifdef IF_FLUSH_EN
    end else if (flush) begin
      fs_pc <= flush_pc;
`endif
    end else if (handoff) begin
      fs_pc <= next_pc;
    end
  end

  // Instruction buffer: captures the response that belongs to the current PC.
  always_ff @(posedge clk) begin
    if (reset)                                   fs_inst <= '0;
    else if (state == S_WAIT && inst_sram.data_ok) fs_inst <= inst_sram.rdata;
  end

  // Discard flag: marks one response still in flight that no longer matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard <= !inst_sram.data_ok && (discard || state == S_WAIT);
`ifdef IF_FLUSH_EN
    end else if (flush) begin
      discard <= !inst_sram.data_ok && (discard || state == S_WAIT)
                 || req_fire;
`endif
    end else if (discard && inst_sram.data_ok) begin
      discard <= 1'b0;
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch (IF) stage controller for the 5-stage MIPS core.
- Consumes the next-PC value produced by the ID-stage PC-select logic and owns the architectural fetch PC.
- Issues word reads on the SRAM-like instruction bus and delivers {pc, inst} to ID through a valid/allowin handshake.
- Non-pipelined fetch: at most one outstanding bus request; returned instruction is buffered until ID accepts it.

Parameters:
- RESET_PC, 32'hBFC00000, address of the first fetch after reset.
- PC_W, 32, width of PC and of the instruction word.

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- id_nextpc_valid  in  1  ID holds a valid instruction; id_nextpc is meaningful.
- id_nextpc  in  32  next fetch address computed by ID (PC+4, jump, register or branch target).
- fs_pc  out  32  PC of the instruction currently owned by IF; fed back to ID as its current-PC input.
- inst_sram_req  out  1  bus request.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'd2 (word).
- inst_sram_addr  out  32  fetch address; equals fs_pc while req is high.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  returned instruction.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- fs_to_ds_valid  out  1  {fs_pc, fs_inst} is valid for ID.
- fs_inst  out  32  instruction word for ID.

Behaviour:
- Reset values:
  - state=S_REQ (first request raised on the first cycle reset is low).
  - fs_pc=RESET_PC.
  - fs_inst=0, fs_to_ds_valid=0, inst_sram_req=0.
- States:
  - S_REQ: req=1. On addr_ok go to S_WAIT.
  - S_WAIT: req=0. On data_ok latch rdata into fs_inst, set fs_to_ds_valid=1, go to S_HOLD.
  - S_HOLD: fs_to_ds_valid=1. On ds_allowin, hand off and compute the next address, then go to S_REQ.
- Next address, sampled in the hand-off cycle (fs_to_ds_valid & ds_allowin):
  - id_nextpc_valid=1: id_nextpc (delay-slot semantics; ID's branch targets the instruction after the one in IF).
  - id_nextpc_valid=0: fs_pc+32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Hand-off cycle: fs_to_ds_valid drops next cycle; fs_pc updates next cycle.
- Timing:
  - Latency is 1 cycle from hand-off to req high.
  - Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD), each stretched by bus waits.
  - data_ok in the same cycle as addr_ok is not legal on this bus; data arrives at least one cycle after addr_ok.
- inst_sram_addr and req stay stable until addr_ok (no request withdrawal).
- data_ok while not in S_WAIT: ignored (bus protocol violation; assertion in the bench).
- Reset mid-operation: returns to the reset state immediately. An outstanding response arriving after reset is dropped via a 1-bit discard flag, set when reset hits in S_WAIT. The flag clears on the next data_ok, and no new request issues until it is clear.
- fs_pc[1:0]!=0 is fetched as-is; no alignment checking.

Optional Feature:
- Macro IF_FLUSH_EN.
- When defined, adds ports:
  - flush  in  1  redirect request.
  - flush_pc  in  32  redirect address.
- flush=1 in any state:
  - fs_to_ds_valid cleared next cycle.
  - fs_pc<=flush_pc, state<=S_REQ.
  - If a request was accepted but not returned (S_WAIT, or S_REQ with addr_ok the same cycle), set the discard flag.
- flush has priority over the hand-off; flush and reset together: reset wins.
- When not defined: ports absent, no discard-on-flush logic, behaviour exactly as above.

Decomposition:
- Shared header: state encodings S_REQ/S_WAIT/S_HOLD, RESET_PC value, inst_sram size encoding.
- Shared header: FS_TO_DS_BUS_WR={fs_pc, fs_inst}=64 bits, alongside the existing PC-source macros.
- No sub-module needed; a single FSM plus PC/instruction registers.

Test Plan:
- Reset, then addr_ok on cycle 1 and data_ok on cycle 2 returning 0x24080001, ds_allowin=1, id_nextpc_valid=0 -> addr 0xBFC00000, fs_to_ds_valid with fs_inst=0x24080001, next request at 0xBFC00004.
- ds_allowin held 0 for 5 cycles in S_HOLD -> fs_to_ds_valid, fs_pc and fs_inst stable, req=0 throughout.
- id_nextpc_valid=1 with id_nextpc=0xBFC00100 at hand-off -> next inst_sram_addr=0xBFC00100.
- addr_ok delayed 4 cycles -> req and addr held constant for 4 cycles, then a single transaction.
- Reset asserted in S_WAIT, stale data_ok 2 cycles later -> data dropped, fetch restarts at 0xBFC00000, first fs_inst comes from the new response.
- IF_FLUSH_EN: flush with flush_pc=0xBFC00380 in S_WAIT -> in-flight data discarded, next addr 0xBFC00380, no stale fs_to_ds_valid.
